hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- ID-stage hazard and stall controller for the 5-stage MIPS pipeline.
- Complements the forwarding unit: it handles the hazards forwarding cannot resolve.
  - Load-use stalls, with bubble insertion into ID/EX.
  - Taken-branch flush of IF/ID.
  - Multi-cycle data-memory wait, which freezes the whole pipeline.
- Sits between the IF/ID and ID/EX pipeline registers; drives PC and pipeline-register write enables.
- Keeps saturating stall and flush counters for performance measurement.

Parameters:
MEM_LAT, 3, data-memory access latency in cycles; legal range >=1; 1 means no memory freeze.
CNT_W, 16, width of the performance counters.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  asynchronous, active-low reset.
IF_ID_RegRs  input  5  rs field of the instruction in ID.
IF_ID_RegRt  input  5  rt field of the instruction in ID.
ID_EX_memRead  input  1  instruction in EX is a load.
ID_EX_RegRt  input  5  destination rt of the instruction in EX.
EX_MEM_memRead  input  1  instruction in MEM reads data memory.
EX_MEM_memWrite  input  1  instruction in MEM writes data memory.
branch_taken_i  input  1  branch in ID resolved taken.
PCWrite_o  output  1  PC update enable.
IF_ID_Write_o  output  1  IF/ID register write enable.
IF_ID_Flush_o  output  1  zero the IF/ID register on the next edge.
ID_EX_Bubble_o  output  1  select zero control signals into ID/EX.
Pipe_Freeze_o  output  1  hold the ID/EX, EX/MEM and MEM/WB registers.
stall_cnt_o  output  CNT_W  cycles with PCWrite_o=0, outside reset.
flush_cnt_o  output  CNT_W  cycles with IF_ID_Flush_o=1.

Behaviour:
- State: FSM {RUN, MEM_WAIT}, plus wait_cnt (width ceil(log2(MEM_LAT))+1) and two counters.
- Outputs are combinational from state and inputs.
- Reset (rst_i=0, asynchronous):
  - state=RUN, wait_cnt=0, both counters=0.
  - While rst_i=0: PCWrite_o=0, IF_ID_Write_o=0, IF_ID_Flush_o=0, ID_EX_Bubble_o=0, Pipe_Freeze_o=0.
- Definitions:
  - memop = EX_MEM_memRead | EX_MEM_memWrite.
  - loaduse = ID_EX_memRead & (ID_EX_RegRt!=0) & (ID_EX_RegRt==IF_ID_RegRs | ID_EX_RegRt==IF_ID_RegRt).
- freeze condition:
  - In RUN: freeze = memop & (MEM_LAT>1).
  - In MEM_WAIT: freeze = (wait_cnt!=0).
- Transitions:
  - RUN with freeze: load wait_cnt=MEM_LAT-2, go to MEM_WAIT.
  - MEM_WAIT with wait_cnt!=0: decrement wait_cnt.
  - MEM_WAIT with wait_cnt==0: this is the completion cycle; freeze=0; go to RUN.
  - Total freeze per access = MEM_LAT-1 cycles.
  - A new memop arriving in EX/MEM right after completion starts a fresh wait.
- Output priority, highest first:
  1. freeze: Pipe_Freeze_o=1, PCWrite_o=0, IF_ID_Write_o=0, Bubble=0, Flush=0.
  2. loaduse: PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1, Flush=0. Exactly one bubble per hazard, because the load advances to MEM next cycle.
  3. branch_taken_i: PCWrite_o=1, IF_ID_Write_o=1, IF_ID_Flush_o=1.
  4. otherwise: PCWrite_o=1, IF_ID_Write_o=1, all others 0.
- Branch interaction:
  - A taken branch coinciding with freeze or loaduse is not flushed that cycle.
  - The branch stays in ID and is flushed on the first unblocked cycle.
- Counters:
  - stall_cnt increments on each edge where PCWrite_o=0 and rst_i=1.
  - flush_cnt increments on each edge where IF_ID_Flush_o=1.
  - Both saturate at all-ones; no wrap.
- Reset mid-operation: reset during MEM_WAIT aborts the wait immediately; freeze drops asynchronously.
- Rs/Rt comparisons are full 5-bit equality. Register 0 never causes a stall.

Test Plan:
1. Load-use stall, MEM_LAT=3:
   - Stimulus: ID_EX_memRead=1, ID_EX_RegRt=8, IF_ID_RegRs=8, memop=0.
   - Response: PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1 for one cycle; stall_cnt_o=1 afterwards.
2. Register-0 exclusion:
   - Stimulus: same as scenario 1 but ID_EX_RegRt=0 and IF_ID_RegRt=0.
   - Response: no stall; PCWrite_o=1; stall_cnt_o stays 0.
3. Memory freeze, MEM_LAT=3:
   - Stimulus: EX_MEM_memRead=1 for one instruction, dropping on the edge after completion.
   - Response: Pipe_Freeze_o=1 for exactly 2 cycles, then 0 on the completion cycle; stall_cnt_o=2.
4. Branch behind a load-use hazard:
   - Stimulus: branch_taken_i=1 together with loaduse.
   - Response: Flush=0, Bubble=1. Next cycle (hazard cleared, branch still taken): IF_ID_Flush_o=1, flush_cnt_o=1.
5. Reset mid-wait:
   - Stimulus: rst_i=0 in the first MEM_WAIT cycle.
   - Response: Pipe_Freeze_o drops without a clock edge; counters=0. After release with memop=1, a full 2-cycle freeze occurs again.
6. Counter saturation:
   - Stimulus: hold freeze (repeated memops) for 70000 stall cycles.
   - Response: stall_cnt_o=16'hFFFF and it stays there.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard/stall controller: load-use bubbles, taken-branch IF/ID flush,
// multi-cycle data-memory freeze, and saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_RegRs,
  input  logic [4:0]       IF_ID_RegRt,
  input  logic             ID_EX_memRead,
  input  logic [4:0]       ID_EX_RegRt,
  input  logic             EX_MEM_memRead,
  input  logic             EX_MEM_memWrite,
  input  logic             branch_taken_i,
  output logic             PCWrite_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Bubble_o,
  output logic             Pipe_Freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WCW       = $clog2(MEM_LAT) + 1;
  localparam int WAIT_LOAD = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WCW-1:0]   r_wait_cnt;
  logic [WCW-1:0]   w_wait_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_memop;
  logic w_loaduse;
  logic w_freeze;

  assign w_memop   = EX_MEM_memRead | EX_MEM_memWrite;
  assign w_loaduse = ID_EX_memRead && (ID_EX_RegRt != 5'd0) &&
                     ((ID_EX_RegRt == IF_ID_RegRs) || (ID_EX_RegRt == IF_ID_RegRt));

  always_comb begin
    w_freeze = 1'b0;
    if (r_state == RUN) w_freeze = w_memop && (MEM_LAT > 1);
    else                w_freeze = (r_wait_cnt != '0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    unique case (r_state)
      RUN: begin
        if (w_freeze) begin
          w_next_state   = MEM_WAIT;
          w_wait_cnt_nxt = WCW'(WAIT_LOAD);
        end
      end
      MEM_WAIT: begin
        // wait_cnt==0 is the completion cycle: no freeze, back to RUN
        if (r_wait_cnt != '0) w_wait_cnt_nxt = r_wait_cnt - 1'b1;
        else                  w_next_state   = RUN;
      end
      default: w_next_state = RUN;
    endcase
  end

  always_comb begin
    PCWrite_o      = 1'b0;
    IF_ID_Write_o  = 1'b0;
    IF_ID_Flush_o  = 1'b0;
    ID_EX_Bubble_o = 1'b0;
    Pipe_Freeze_o  = 1'b0;
    if (!rst_i) begin
      PCWrite_o = 1'b0;
    end else if (w_freeze) begin
      Pipe_Freeze_o = 1'b1;
    end else if (w_loaduse) begin
      ID_EX_Bubble_o = 1'b1;
    end else begin
      PCWrite_o     = 1'b1;
      IF_ID_Write_o = 1'b1;
      IF_ID_Flush_o = branch_taken_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!PCWrite_o && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (IF_ID_Flush_o && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios, randomized
// traffic against a phase-counting reference model, and counter saturation.
module tb_hazard_stall_ctrl;

  localparam int LAT    = 3;
  localparam int CW     = 16;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs, rt, ex_rt;
  logic          ex_mr, mem_rd, mem_wr, br;
  logic          pcw, ifw, flush, bubble, freeze;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: m_phase = position within a memory access (0 idle, 1..LAT-1 frozen, LAT completion)
  int m_phase;
  int m_stall;
  int m_flush;

  hazard_stall_ctrl #(.MEM_LAT(LAT), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .IF_ID_RegRs    (rs),
    .IF_ID_RegRt    (rt),
    .ID_EX_memRead  (ex_mr),
    .ID_EX_RegRt    (ex_rt),
    .EX_MEM_memRead (mem_rd),
    .EX_MEM_memWrite(mem_wr),
    .branch_taken_i (br),
    .PCWrite_o      (pcw),
    .IF_ID_Write_o  (ifw),
    .IF_ID_Flush_o  (flush),
    .ID_EX_Bubble_o (bubble),
    .Pipe_Freeze_o  (freeze),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_phase();
    if (m_phase == 0 && (mem_rd || mem_wr) && LAT > 1) return 1;
    return m_phase;
  endfunction

  // {PCWrite, IF_ID_Write, Flush, Bubble, Freeze}
  function automatic logic [4:0] model_outs();
    int  p;
    bit  fz, lu;
    p  = eff_phase();
    fz = (p >= 1) && (p <= LAT - 1);
    lu = ex_mr && (ex_rt != 0) && ((ex_rt == rs) || (ex_rt == rt));
    if (fz) return 5'b00001;
    if (lu) return 5'b00010;
    return {2'b11, br, 2'b00};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic cycle(input string tag, input bit do_chk);
    logic [4:0] e;
    int         p;
    e = model_outs();
    p = eff_phase();
    @(negedge clk);
    if (do_chk) begin
      chk({tag, "_outs"}, {pcw, ifw, flush, bubble, freeze}, e);
      chk({tag, "_stall"}, stall_cnt, m_stall);
      chk({tag, "_flush"}, flush_cnt, m_flush);
    end
    @(posedge clk);
    if (!e[4] && m_stall < CNTMAX) m_stall++;
    if (e[2] && m_flush < CNTMAX) m_flush++;
    if (p == 0) m_phase = 0;
    else        m_phase = (p == LAT) ? 0 : p + 1;
    #1;
  endtask

  task automatic idle_inputs();
    rs = 5'd0; rt = 5'd0; ex_rt = 5'd0;
    ex_mr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; br = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #3;
    chk("reset_outs", {pcw, ifw, flush, bubble, freeze}, 5'b00000);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_flush", flush_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    cycle("idle", 1'b1);

    // Load-use stall then release
    ex_mr = 1'b1; ex_rt = 5'd8; rs = 5'd8; rt = 5'd3;
    cycle("loaduse", 1'b1);
    ex_mr = 1'b0;
    cycle("loaduse_after", 1'b1);
    chk("loaduse_stallcnt", stall_cnt, 1);

    // Register 0 never stalls
    ex_mr = 1'b1; ex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
    cycle("reg0", 1'b1);
    chk("reg0_pcw", pcw, 1'b1);
    ex_mr = 1'b0;

    // Memory freeze: 2 frozen cycles then completion
    mem_rd = 1'b1;
    cycle("frz1", 1'b1);
    cycle("frz2", 1'b1);
    cycle("frz_done", 1'b1);
    mem_rd = 1'b0;
    cycle("frz_after", 1'b1);
    chk("frz_stallcnt", stall_cnt, 3);

    // Branch behind a load-use hazard is flushed one cycle later
    ex_mr = 1'b1; ex_rt = 5'd5; rt = 5'd5; rs = 5'd1; br = 1'b1;
    cycle("br_lu", 1'b1);
    ex_mr = 1'b0;
    cycle("br_flush", 1'b1);
    br = 1'b0;
    cycle("br_after", 1'b1);
    chk("br_flushcnt", flush_cnt, 1);
    idle_inputs();

    // Reset in the first MEM_WAIT cycle drops freeze without a clock edge
    mem_rd = 1'b1;
    cycle("rst_pre", 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_outs", {pcw, ifw, flush, bubble, freeze}, 5'b00000);
    chk("rstmid_stall", stall_cnt, 0);
    chk("rstmid_flush", flush_cnt, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cycle("rst_frz1", 1'b1);
    cycle("rst_frz2", 1'b1);
    cycle("rst_done", 1'b1);
    mem_rd = 1'b0;
    cycle("rst_after", 1'b1);

    // Randomized traffic, small register numbers to force matches
    for (int i = 0; i < 2000; i++) begin
      rs     = 5'($urandom_range(0, 3));
      rt     = 5'($urandom_range(0, 3));
      ex_rt  = 5'($urandom_range(0, 3));
      ex_mr  = ($urandom_range(0, 3) == 0);
      mem_rd = ($urandom_range(0, 4) == 0);
      mem_wr = ($urandom_range(0, 6) == 0);
      br     = ($urandom_range(0, 3) == 0);
      cycle("rand", 1'b1);
    end

    // Saturation: freeze plus load-use keeps PCWrite low every cycle
    idle_inputs();
    mem_rd = 1'b1; ex_mr = 1'b1; ex_rt = 5'd8; rs = 5'd8;
    for (int i = 0; i < 65600; i++) cycle("sat_run", 1'b0);
    chk("sat_stall", stall_cnt, 16'hFFFF);
    for (int i = 0; i < 4; i++) cycle("sat_hold", 1'b1);
    chk("sat_stall_hold", stall_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
